// File: rtl/fmad_sched.sv
// Round-robin scheduler sharing one pipelined single-precision fmad between
// NREQ requesters. One issue per cycle, 4-cycle issue-to-response latency,
// per-requester outstanding limit and a global issue hold.
module fmad_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned MAXOUT = 4,
  parameter int unsigned TW     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_x,
  input  logic [32*NREQ-1:0]   req_y,
  input  logic [32*NREQ-1:0]   req_z,
  input  logic                 hold,
  output logic                 fmad_req,
  output logic [31:0]          fmad_x,
  output logic [31:0]          fmad_y,
  output logic [31:0]          fmad_z,
  input  logic [31:0]          fmad_rslt,
  input  logic [4:0]           fmad_flag,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_rslt,
  output logic [4:0]           resp_flag,
  output logic                 busy
);

  localparam int unsigned CW   = $clog2(MAXOUT + 1);
  localparam int unsigned NSTG = 4;

  logic [TW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q [NREQ];
  logic [CW-1:0]   cnt_d [NREQ];
  logic [NSTG-1:0] tvld_q;
  logic [TW-1:0]   ttag_q [NSTG];
  logic [31:0]     x_q, y_q, z_q;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic            gnt_any;
  logic [TW-1:0]   gidx;

  // Response strobe decoded from the last tag stage; payload passes straight through.
  always_comb begin
    resp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (tvld_q[NSTG-1] && (ttag_q[NSTG-1] == TW'(i))) resp_valid[i] = 1'b1;
    end
  end

  assign resp_rslt = fmad_rslt;
  assign resp_flag = fmad_flag;
  assign busy      = |tvld_q;

  // Eligibility: a retiring response frees its slot in the same cycle, so the
  // limit is checked against the count net of this cycle's decrement.
  always_comb begin
    logic [CW-1:0] cnt_eff;
    cnt_eff = '0;
    elig    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_eff = cnt_q[i] - CW'(resp_valid[i]);
      elig[i] = req_valid[i] & ~hold & reset & (cnt_eff < CW'(MAXOUT));
    end
  end

  // Round-robin pick: first eligible index at or after ptr, wrapping.
  always_comb begin
    logic [TW:0] idx;
    idx     = '0;
    grant   = '0;
    gnt_any = 1'b0;
    gidx    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = {1'b0, ptr_q} + (TW+1)'(off);
      if (idx >= (TW+1)'(NREQ)) idx = idx - (TW+1)'(NREQ);
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_any && (idx == (TW+1)'(i)) && elig[i]) begin
          gnt_any  = 1'b1;
          gidx     = TW'(i);
          grant[i] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign fmad_req  = gnt_any;

  // Next pointer and outstanding-count updates.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gidx == TW'(NREQ - 1)) ? '0 : gidx + TW'(1);
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i] + CW'(grant[i]) - CW'(resp_valid[i]);
    end
  end

  // State: pointer, counters, tag pipe and operand registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q  <= '0;
      tvld_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      for (int unsigned s = 0; s < NSTG; s++) ttag_q[s] <= '0;
    end else begin
      ptr_q  <= ptr_d;
      tvld_q <= {tvld_q[NSTG-2:0], gnt_any};
      ttag_q[0] <= gidx;
      for (int unsigned s = 1; s < NSTG; s++) ttag_q[s] <= ttag_q[s-1];
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
      if (gnt_any) begin
        x_q <= req_x[32*gidx +: 32];
        y_q <= req_y[32*gidx +: 32];
        z_q <= req_z[32*gidx +: 32];
      end
    end
  end

  assign fmad_x = x_q;
  assign fmad_y = y_q;
  assign fmad_z = z_q;

endmodule

// File: tb/tb_fmad_sched.sv
// Bench for fmad_sched: a behavioural 4-cycle fmad stub, a response
// scoreboard, and one task per scenario.
module tb_fmad_sched;

  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Main instance (MAXOUT=4)
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic               hold = 1'b0;
  logic               fmad_req;
  logic [31:0]        fmad_x, fmad_y, fmad_z;
  logic [31:0]        stub_rslt = '0;
  logic [4:0]         stub_flag = '0;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_rslt;
  logic [4:0]         resp_flag;
  logic               busy;

  // Second instance (MAXOUT=1) for the outstanding-limit scenario
  logic [NREQ-1:0]    m1_valid = '0;
  logic [NREQ-1:0]    m1_ready;
  logic [32*NREQ-1:0] m1_ops = '0;
  logic               m1_hold = 1'b0;
  logic               m1_fmad_req;
  logic [31:0]        m1_fx, m1_fy, m1_fz;
  logic [31:0]        m1_rin = '0;
  logic [4:0]         m1_fin = '0;
  logic [NREQ-1:0]    m1_resp_valid;
  logic [31:0]        m1_resp_rslt;
  logic [4:0]         m1_resp_flag;
  logic               m1_busy;

  fmad_sched #(.NREQ(NREQ), .MAXOUT(4), .TW(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .hold(hold),
    .fmad_req(fmad_req), .fmad_x(fmad_x), .fmad_y(fmad_y), .fmad_z(fmad_z),
    .fmad_rslt(stub_rslt), .fmad_flag(stub_flag),
    .resp_valid(resp_valid), .resp_rslt(resp_rslt), .resp_flag(resp_flag),
    .busy(busy)
  );

  fmad_sched #(.NREQ(NREQ), .MAXOUT(1), .TW(3)) dut_m1 (
    .clk(clk), .reset(reset),
    .req_valid(m1_valid), .req_ready(m1_ready),
    .req_x(m1_ops), .req_y(m1_ops), .req_z(m1_ops),
    .hold(m1_hold),
    .fmad_req(m1_fmad_req), .fmad_x(m1_fx), .fmad_y(m1_fy), .fmad_z(m1_fz),
    .fmad_rslt(m1_rin), .fmad_flag(m1_fin),
    .resp_valid(m1_resp_valid), .resp_rslt(m1_resp_rslt), .resp_flag(m1_resp_flag),
    .busy(m1_busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference fmad behaviour for the operands used here: {flag, rslt}.
  function automatic logic [36:0] fma_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
    if (x == 32'h3f800000 && y == 32'h40000000 && z == 32'h3f800000)
      return {5'h00, 32'h40400000};
    if (x == 32'h7f800000 && y == 32'h00000000)
      return {5'h10, 32'hffc00000};
    if (x[30:23] == 8'hff && x[22:0] != 23'd0 && !x[22])
      return {5'h10, x | 32'h00400000};
    return {x[4:0] ^ z[4:0], (x + y) ^ z};
  endfunction

  // fmad stub: operands valid the cycle after issue, result visible 4 cycles after issue.
  logic        en0_q = 1'b0;
  logic [36:0] p2 = '0, p3 = '0;
  always @(posedge clk) begin
    en0_q <= fmad_req;
    if (en0_q) p2 <= fma_ref(fmad_x, fmad_y, fmad_z);
    p3 <= p2;
    {stub_flag, stub_rslt} <= p3;
  end

  typedef struct {
    int          due;
    int          id;
    logic [31:0] r;
    logic [4:0]  f;
  } sb_t;
  sb_t sbq[$];

  // Scoreboard: each expected response is due exactly 4 cycles after its issue.
  always @(negedge clk) begin : mon
    sb_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      checks++;
      if (resp_valid !== (4'b0001 << e.id) || resp_rslt !== e.r || resp_flag !== e.f) begin
        failures++;
        $display("FAIL resp cyc=%0d got valid=%b rslt=%h flag=%h exp valid=%b rslt=%h flag=%h",
                 cyc, resp_valid, resp_rslt, resp_flag, 4'b0001 << e.id, e.r, e.f);
      end
    end else if (resp_valid !== 4'b0000) begin
      checks++;
      failures++;
      $display("FAIL resp_unexpected cyc=%0d got valid=%b exp valid=0000", cyc, resp_valid);
    end
  end

  function automatic int exp_grant(input logic [3:0] v, input int p);
    for (int off = 0; off < 4; off++) begin
      if (v[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z);
    req_x[32*i +: 32] = x;
    req_y[32*i +: 32] = y;
    req_z[32*i +: 32] = z;
  endtask

  task automatic push_exp(input int id, input logic [36:0] fr);
    sb_t e;
    e.due = cyc + 4;
    e.id  = id;
    e.r   = fr[31:0];
    e.f   = fr[36:32];
    sbq.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    req_valid = '0;
    m1_valid = '0;
    hold = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = '1;
    m1_valid = 4'b0100;
    for (int i = 0; i < 4; i++) set_ops(i, 32'h11111111 * (i + 1), 32'h1, 32'h2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++;
    if (fmad_req !== 1'b0) begin failures++; $display("FAIL reset_fmad_req got=%b exp=0", fmad_req); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if ({fmad_x, fmad_y, fmad_z} !== 96'd0) begin
      failures++; $display("FAIL reset_operands got=%h %h %h exp=0", fmad_x, fmad_y, fmad_z);
    end
    checks++;
    if (m1_ready !== 4'b0000) begin failures++; $display("FAIL reset_m1_ready got=%b exp=0000", m1_ready); end
    req_valid = '0;
    m1_valid = '0;
    next_cycle();
    reset = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_single();
    set_ops(1, 32'h3f800000, 32'h40000000, 32'h3f800000);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
    checks++;
    if (fmad_req !== 1'b1) begin failures++; $display("FAIL single_fmad_req got=%b exp=1", fmad_req); end
    push_exp(1, {5'h00, 32'h40400000});
    exp_ptr = 2;
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (fmad_x !== 32'h3f800000 || fmad_y !== 32'h40000000 || fmad_z !== 32'h3f800000) begin
      failures++; $display("FAIL single_operands got=%h %h %h exp=3f800000 40000000 3f800000",
                           fmad_x, fmad_y, fmad_z);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    repeat (6) next_cycle();
  endtask

  task automatic test_round_robin();
    int g;
    logic [31:0] prev_x;
    prev_x = '0;
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 32'h40000000 | (i << 4), 32'h00000100 + i, 32'h00A00000 + i);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      g = exp_grant(4'b1111, exp_ptr);
      checks++;
      if (req_ready !== (4'b0001 << g)) begin
        failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'b0001 << g);
      end
      checks++;
      if (fmad_req !== 1'b1) begin failures++; $display("FAIL rr_fmad_req k=%0d got=%b exp=1", k, fmad_req); end
      if (k > 0) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy k=%0d got=%b exp=1", k, busy); end
        checks++;
        if (fmad_x !== prev_x) begin failures++; $display("FAIL rr_fmad_x k=%0d got=%h exp=%h", k, fmad_x, prev_x); end
      end
      push_exp(g, fma_ref(req_x[32*g +: 32], req_y[32*g +: 32], req_z[32*g +: 32]));
      prev_x = req_x[32*g +: 32];
      exp_ptr = (g + 1) % 4;
      next_cycle();
    end
    req_valid = '0;
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      checks++;
      if (busy !== (d < 4)) begin failures++; $display("FAIL rr_drain_busy d=%0d got=%b exp=%b", d, busy, d < 4); end
      next_cycle();
    end
  endtask

  task automatic test_maxout1();
    logic [3:0] exp_r;
    do_reset();
    m1_valid = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_r = (k % 4 == 0) ? 4'b0100 : 4'b0000;
      checks++;
      if (m1_ready !== exp_r) begin failures++; $display("FAIL maxout1_ready k=%0d got=%b exp=%b", k, m1_ready, exp_r); end
      next_cycle();
    end
    m1_valid = '0;
    repeat (6) next_cycle();
    @(negedge clk);
    checks++;
    if (m1_busy !== 1'b0) begin failures++; $display("FAIL maxout1_busy got=%b exp=0", m1_busy); end
    next_cycle();
  endtask

  task automatic test_hold();
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 32'h3e000000 + i, 32'h00000200 * (i + 1), 32'h00000033 + i);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      hold = (k >= 2 && k <= 4);
      @(negedge clk);
      g = hold ? -1 : exp_grant(4'b1111, exp_ptr);
      checks++;
      if (g < 0) begin
        if (req_ready !== 4'b0000 || fmad_req !== 1'b0) begin
          failures++; $display("FAIL hold_blocked k=%0d got ready=%b req=%b exp ready=0000 req=0", k, req_ready, fmad_req);
        end
      end else begin
        if (req_ready !== (4'b0001 << g) || fmad_req !== 1'b1) begin
          failures++; $display("FAIL hold_grant k=%0d got ready=%b req=%b exp ready=%b req=1", k, req_ready, fmad_req, 4'b0001 << g);
        end
        push_exp(g, fma_ref(req_x[32*g +: 32], req_y[32*g +: 32], req_z[32*g +: 32]));
        exp_ptr = (g + 1) % 4;
      end
      next_cycle();
    end
    req_valid = '0;
    hold = 1'b0;
    repeat (6) next_cycle();
  endtask

  task automatic test_special();
    set_ops(3, 32'h7f800000, 32'h00000000, 32'h00000000);
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL special_ready3 got=%b exp=1000", req_ready); end
    push_exp(3, {5'h10, 32'hffc00000});
    next_cycle();
    set_ops(0, 32'h7f800001, 32'h3f800000, 32'h00000000);
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL special_ready0 got=%b exp=0001", req_ready); end
    push_exp(0, {5'h10, 32'h7fc00001});
    exp_ptr = 1;
    next_cycle();
    req_valid = '0;
    repeat (6) next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ops(0, 32'h3f800000, 32'h3f800000, 32'h0);
    set_ops(1, 32'h40000000, 32'h40000000, 32'h0);
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_grant0 got=%b exp=0001", req_ready); end
    next_cycle();
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmid_grant1 got=%b exp=0010", req_ready); end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || fmad_req !== 1'b0 || busy !== 1'b0 || resp_valid !== 4'b0000) begin
      failures++; $display("FAIL rmid_outputs got ready=%b req=%b busy=%b resp=%b exp all zero",
                           req_ready, fmad_req, busy, resp_valid);
    end
    checks++;
    if ({fmad_x, fmad_y, fmad_z} !== 96'd0) begin
      failures++; $display("FAIL rmid_operands got=%h %h %h exp=0", fmad_x, fmad_y, fmad_z);
    end
    req_valid = '0;
    repeat (2) next_cycle();
    reset = 1'b1;
    exp_ptr = 0;
    repeat (6) next_cycle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    next_cycle();
    for (int i = 0; i < 4; i++) set_ops(i, 32'h3f000000 + i, 32'h5, 32'h7);
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_first_grant got=%b exp=0001", req_ready); end
    push_exp(0, fma_ref(32'h3f000000, 32'h5, 32'h7));
    next_cycle();
    req_valid = '0;
    repeat (6) next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_maxout1();
    test_hold();
    test_special();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
